// File: rtl/fifo_burst_writer.sv
// Drains a show-ahead pixel FIFO into the SDRAM write port in fixed-length bursts.
// It generates frame-relative burst addresses, wraps at end of frame and realigns on frame_start.
module fifo_burst_writer #(
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 10,
  parameter int ADDR_WIDTH  = 24,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_WORDS = 307200,
  parameter int BASE_ADDR   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic                   fifo_empty,
  input  logic [COUNT_WIDTH-1:0] fifo_count,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   fifo_read,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [ADDR_WIDTH-1:0]  cmd_addr,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_last,
  output logic                   frame_done,
  output logic                   busy
);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int WW = $clog2(FRAME_WORDS + 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t          state;
  logic [BW-1:0]   beat_cnt;
  logic [WW-1:0]   word_cnt;
  logic [WW-1:0]   word_nxt;
  logic            restart_pend;
  logic            beat;
  logic            last_beat;
  logic            wrap;

  // Beats stall on an empty FIFO so no word is lost or duplicated.
  assign wr_valid  = (state == DATA) & ~fifo_empty;
  assign beat      = wr_valid & wr_ready;
  assign fifo_read = beat;
  assign wr_last   = wr_valid & (beat_cnt == BW'(BURST_LEN - 1));
  assign last_beat = beat & wr_last;
  assign wr_data   = fifo_data;
  assign busy      = (state != IDLE);
  assign word_nxt  = word_cnt + WW'(BURST_LEN);
  assign wrap      = (word_nxt == WW'(FRAME_WORDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cmd_valid    <= 1'b0;
      cmd_addr     <= BASE;
      frame_done   <= 1'b0;
      beat_cnt     <= '0;
      word_cnt     <= '0;
      restart_pend <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            cmd_addr <= BASE;
            word_cnt <= '0;
          end
          if (fifo_count >= COUNT_WIDTH'(BURST_LEN)) begin
            state     <= CMD;
            cmd_valid <= 1'b1;
          end
        end
        CMD: begin
          if (frame_start) restart_pend <= 1'b1;
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            beat_cnt  <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (frame_start) restart_pend <= 1'b1;
          if (beat) beat_cnt <= beat_cnt + 1'b1;
          if (last_beat) begin
            state        <= IDLE;
            restart_pend <= 1'b0;
            frame_done   <= wrap;
            // A restart that lands on the final beat still takes effect right here.
            if (wrap || restart_pend || frame_start) begin
              cmd_addr <= BASE;
              word_cnt <= '0;
            end else begin
              cmd_addr <= cmd_addr + ADDR_WIDTH'(BURST_LEN);
              word_cnt <= word_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_burst_writer.sv
// Bench for fifo_burst_writer: FIFO model plus data/address scoreboard queues.
module tb_fifo_burst_writer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic        fifo_empty;
  logic [9:0]  fifo_count;
  logic [15:0] fifo_data;
  logic        fifo_read;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_addr;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        wr_last;
  logic        frame_done;
  logic        busy;

  fifo_burst_writer #(
    .DATA_WIDTH(16), .COUNT_WIDTH(10), .ADDR_WIDTH(24),
    .BURST_LEN(16), .FRAME_WORDS(64), .BASE_ADDR(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .fifo_empty(fifo_empty), .fifo_count(fifo_count), .fifo_data(fifo_data),
    .fifo_read(fifo_read), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_last(wr_last), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // show-ahead FIFO model
  logic [15:0] mem [0:1023];
  int          wp = 0;
  int          rp = 0;
  logic        stall = 1'b0;
  logic [15:0] seq = 16'hA000;
  assign fifo_empty = (wp == rp) || stall;
  assign fifo_count = 10'(wp - rp);
  assign fifo_data  = mem[rp % 1024];
  always @(posedge clk) if (fifo_read) rp <= rp + 1;

  logic [15:0] dq [$];
  logic [23:0] aq [$];
  int n_vec = 0;
  int n_bad = 0;
  int beat_idx = 0;
  int n_pop = 0;
  int n_fd = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wp % 1024] = seq;
      dq.push_back(seq);
      seq = seq + 16'd1;
      wp++;
    end
  endtask

  task automatic burst(input logic [23:0] addr);
    @(posedge clk); #1;
    aq.push_back(addr);
    push_words(16);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || dq.size() != 0 || aq.size() != 0) && n < 300);
    chk(tag, 32'(n < 300), 1);
  endtask

  task automatic wait_beat(input int idx);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (beat_idx != idx && n < 100);
    chk("beat_wait", 32'(n < 100), 1);
  endtask

  // scoreboard monitor
  always @(negedge clk) if (rst_n) begin
    if (cmd_valid && cmd_ready) begin
      if (aq.size() == 0) chk("cmd_extra", 1, 0);
      else chk("cmd_addr", 32'(cmd_addr), 32'(aq.pop_front()));
    end
    chk("fifo_read", 32'(fifo_read), 32'(wr_valid && wr_ready));
    if (wr_valid) begin
      chk("wr_last", 32'(wr_last), 32'(beat_idx == 15));
      if (wr_ready) begin
        if (dq.size() == 0) chk("beat_extra", 1, 0);
        else chk("wr_data", 32'(wr_data), 32'(dq.pop_front()));
        beat_idx = (beat_idx + 1) % 16;
        n_pop++;
      end
    end else begin
      chk("wr_last_idle", 32'(wr_last), 0);
    end
    if (frame_done) n_fd++;
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_valid"}, 32'(cmd_valid), 0);
    chk({tag, "_cmd_addr"}, 32'(cmd_addr), 0);
    chk({tag, "_wr_valid"}, 32'(wr_valid), 0);
    chk({tag, "_wr_last"}, 32'(wr_last), 0);
    chk({tag, "_fifo_read"}, 32'(fifo_read), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int streak;
    int n;
    int pop0;
    rst_n = 1'b0; frame_start = 1'b0; cmd_ready = 1'b1; wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: count threshold, command latency, full-rate burst
    aq.push_back(24'd0);
    push_words(15);
    repeat (3) @(negedge clk);
    chk("t1_below_thr", 32'(cmd_valid), 0);
    chk("t1_below_busy", 32'(busy), 0);
    @(posedge clk); #1 push_words(1);
    @(negedge clk); chk("t1_cmd_not_yet", 32'(cmd_valid), 0);
    @(negedge clk); chk("t1_cmd_rise", 32'(cmd_valid), 1);
    chk("t1_cmd_addr", 32'(cmd_addr), 0);
    n = 0;
    while (!wr_valid && n < 10) begin @(negedge clk); n++; end
    streak = 0;
    for (int i = 0; i < 16; i++) begin
      if (fifo_read) streak++;
      @(negedge clk);
    end
    chk("t1_streak", 32'(streak), 16);
    wait_done("t1_done");
    chk("t1_next_addr", 32'(cmd_addr), 16);

    // 2: command backpressure, then wr_ready toggling
    @(posedge clk); #1 cmd_ready = 1'b0;
    burst(24'd16);
    repeat (4) @(negedge clk);
    chk("t2_cmd_hold", 32'(cmd_valid), 1);
    chk("t2_addr_hold", 32'(cmd_addr), 16);
    pop0 = n_pop;
    @(posedge clk); #1 cmd_ready = 1'b1;
    fork
      for (int i = 0; i < 60; i++) begin @(posedge clk); #1 wr_ready = ~wr_ready; end
      wait_done("t2_done");
    join
    wr_ready = 1'b1;
    chk("t2_pops", 32'(n_pop - pop0), 16);

    // 3: FIFO empty for 3 cycles after beat 7
    burst(24'd32);
    wait_beat(8);
    #1 stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_stall_valid", 32'(wr_valid), 0);
      chk("t3_stall_read", 32'(fifo_read), 0);
      @(posedge clk);
    end
    #1 stall = 1'b0;
    wait_done("t3_done");
    chk("t3_next_addr", 32'(cmd_addr), 48);

    // 4: last burst of the frame wraps
    burst(24'd48);
    wait_done("t4_done");
    @(negedge clk);
    chk("t4_frame_done_cnt", 32'(n_fd), 1);
    chk("t4_wrap_addr", 32'(cmd_addr), 0);
    burst(24'd0);
    wait_done("t4_b5");
    burst(24'd16);
    wait_done("t4_b6");

    // 5: frame_start during the burst at 32
    burst(24'd32);
    wait_beat(5);
    #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    wait_done("t5_done");
    @(negedge clk);
    chk("t5_realign", 32'(cmd_addr), 0);
    chk("t5_no_frame_done", 32'(n_fd), 1);
    burst(24'd0);
    wait_done("t5_next");

    // frame_start while idle
    chk("idle_pre", 32'(cmd_addr), 16);
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    @(negedge clk);
    chk("idle_realign", 32'(cmd_addr), 0);
    chk("idle_no_frame_done", 32'(n_fd), 1);

    // 6: reset during beat 9
    burst(24'd0);
    wait_beat(9);
    #1 rst_n = 1'b0;
    #1 chk_reset("t6");
    repeat (3) @(negedge clk);
    chk_reset("t6_hold");
    wp = rp; dq.delete(); aq.delete(); beat_idx = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    burst(24'd0);
    wait_done("t6_done");
    chk("t6_next_addr", 32'(cmd_addr), 16);
    chk("final_frame_done", 32'(n_fd), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
